// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake, operands and results of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] Diff;
  logic Bout;
  logic V;
  modport master(output start, A, B, Bin, input busy, done, Diff, Bout, V);
  modport slave(input start, A, B, Bin, output busy, done, Diff, Bout, V);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one bit per cycle LSB first, start/done handshake
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_n;
  logic [CW-1:0] cnt;
  logic br, br_n, d, a_msb, b_msb, go, last;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // full-subtract cell on the operand LSBs and next-state decode
  always_comb begin
    d = a_sr[0] ^ b_sr[0] ^ br;
    br_n = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_n = {d, res[WIDTH-1:1]};
    go = state == IDLE && bus.start;
    last = state == RUN && cnt == CW'(WIDTH - 1);
    state_n = go ? RUN : last ? IDLE : state;
  end
  // operand shift registers, borrow, bit counter and registered results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Diff <= '0;
      bus.Bout <= 1'b0;
      bus.V <= 1'b0;
    end else begin
      bus.done <= last;
      if (go) begin
        a_sr <= bus.A;
        b_sr <= bus.B;
        br <= bus.Bin;
        cnt <= '0;
        a_msb <= bus.A[WIDTH-1];
        b_msb <= bus.B[WIDTH-1];
        bus.busy <= 1'b1;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br <= br_n;
        res <= res_n;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          bus.Diff <= res_n;
          bus.Bout <= br_n;
          bus.V <= (a_msb ^ b_msb) & (a_msb ^ d);
          bus.busy <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, handshake corner cases and model sweeps at WIDTH 4 and 8
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(4)) i4();
  serial_subtractor_if #(.WIDTH(8)) i8();
  serial_subtractor #(.WIDTH(4)) dut4(.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  serial_subtractor #(.WIDTH(8)) dut8(.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  typedef struct {
    logic [3:0] a, b;
    logic bin;
    logic [3:0] diff;
    logic bout, v;
  } vec_t;
  vec_t vecs[8];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic logic dn(input int w);
    return w == 4 ? i4.done : i8.done;
  endfunction
  function automatic logic bsy(input int w);
    return w == 4 ? i4.busy : i8.busy;
  endfunction
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int d, output int bo, output int v);
    int sa, sb, sr;
    d = (a - b - bin) & ((1 << w) - 1);
    bo = (a - b - bin) < 0 ? 1 : 0;
    sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
    sb = b >= (1 << (w - 1)) ? b - (1 << w) : b;
    sr = sa - sb - bin;
    v = (sr < -(1 << (w - 1)) || sr > (1 << (w - 1)) - 1) ? 1 : 0;
  endfunction
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic vv);
    int k, bc;
    @(negedge clk);
    if (w == 4) begin
      i4.start = 1'b1; i4.A = a[3:0]; i4.B = b[3:0]; i4.Bin = bin;
    end else begin
      i8.start = 1'b1; i8.A = a; i8.B = b; i8.Bin = bin;
    end
    @(negedge clk);
    i4.start = 1'b0;
    i8.start = 1'b0;
    k = 0;
    bc = 0;
    while (!dn(w) && k < 30) begin
      bc += int'(bsy(w));
      @(negedge clk);
      k++;
    end
    check("latency", k, w);
    check("busy_cycles", bc, w);
    check("busy_at_done", bsy(w), 0);
    if (w == 4) begin
      d = {4'h0, i4.Diff}; bo = i4.Bout; vv = i4.V;
    end else begin
      d = i8.Diff; bo = i8.Bout; vv = i8.V;
    end
    @(negedge clk);
    check("done_pulse_len", dn(w), 0);
  endtask
  initial begin
    logic [7:0] d;
    logic bo, vv;
    int ed, eb, ev, k, nd;
    vecs[0] = '{4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[1] = '{4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1};
    vecs[4] = '{4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1};
    vecs[5] = '{4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1};
    vecs[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[7] = '{4'd8, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1};
    i4.start = 1'b0; i4.A = '0; i4.B = '0; i4.Bin = 1'b0;
    i8.start = 1'b0; i8.A = '0; i8.B = '0; i8.Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", i4.busy, 0);
    check("rst_done", i4.done, 0);
    check("rst_diff", i4.Diff, 0);
    check("rst_bout", i4.Bout, 0);
    check("rst_v", i4.V, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(4, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].bin, d, bo, vv);
      check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
      check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
      check($sformatf("vec%0d_v", i), vv, vecs[i].v);
    end
    @(negedge clk);
    i4.start = 1'b1; i4.A = 4'd5; i4.B = 4'd3; i4.Bin = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      i4.A = 4'(i * 7); i4.B = 4'(i); i4.Bin = 1'b1;
    end
    k = 0;
    while (!i4.done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("hold_start_done", i4.done, 1);
    check("hold_start_diff1", i4.Diff, 2);
    check("hold_start_bout1", i4.Bout, 0);
    i4.A = 4'd9; i4.B = 4'd3; i4.Bin = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!i4.done && k < 12);
    i4.start = 1'b0;
    check("done_spacing", k, 5);
    check("hold_start_diff2", i4.Diff, 6);
    check("hold_start_v2", i4.V, 1);
    @(negedge clk);
    i4.start = 1'b1; i4.A = 4'd5; i4.B = 4'd3; i4.Bin = 1'b0;
    @(negedge clk);
    i4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", i4.busy, 0);
    check("abort_diff", i4.Diff, 0);
    check("abort_bout", i4.Bout, 0);
    check("abort_v", i4.V, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(i4.done);
    end
    check("abort_no_done", nd, 0);
    run_op(4, 8'd8, 8'd1, 1'b0, d, bo, vv);
    check("after_abort_diff", d, 7);
    check("after_abort_v", vv, 1);
    for (int i = 0; i < 512; i++) begin
      run_op(4, 8'(i & 15), 8'((i >> 4) & 15), 1'(i >> 8), d, bo, vv);
      model(4, i & 15, (i >> 4) & 15, i >> 8, ed, eb, ev);
      check($sformatf("sweep%0d_diff", i), d, ed);
      check($sformatf("sweep%0d_bout", i), bo, eb);
      check($sformatf("sweep%0d_v", i), vv, ev);
    end
    for (int i = 0; i < 40; i++) begin
      int a, b, bin;
      a = int'($urandom_range(255));
      b = int'($urandom_range(255));
      bin = int'($urandom_range(1));
      run_op(8, 8'(a), 8'(b), 1'(bin), d, bo, vv);
      model(8, a, b, bin, ed, eb, ev);
      check($sformatf("w8_%0d_diff", i), d, ed);
      check($sformatf("w8_%0d_bout", i), bo, eb);
      check($sformatf("w8_%0d_v", i), vv, ev);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
